// File: rtl/stream_credit_tx.sv
// rtl/stream_credit_tx.sv - credit-gated stream transmitter with registered valid-only link output
module stream_credit_tx #(
    parameter type         T                = logic,
    parameter int unsigned NumCredits       = 4,
    parameter int unsigned CntWidth         = $clog2(NumCredits + 1),
    parameter bit          AssertNoOverflow = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    input  T                    src_data_i,
    output logic                dst_valid_o,
    output T                    dst_data_o,
    input  logic                credit_i,
    output logic [CntWidth-1:0] credit_count_o,
    output logic                idle_o,
    output logic                credit_overflow_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumCredits);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    if (NumCredits < 1) begin : g_bad_credits
        $fatal(1, "stream_credit_tx: NumCredits must be at least 1");
    end

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                dst_valid_q;
    T                    dst_data_q;
    logic                ovf_q, ovf_d;
    logic                send;

    assign src_ready_o       = (cnt_q != '0);
    assign send              = src_valid_i && src_ready_o;
    assign dst_valid_o       = dst_valid_q;
    assign dst_data_o        = dst_data_q;
    assign credit_count_o    = cnt_q;
    assign idle_o            = (cnt_q == CntMax) && !dst_valid_q;
    assign credit_overflow_o = ovf_q;

    // Next credit count: a send and a returned credit cancel; an excess credit saturates and flags overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (send && !credit_i) begin
            cnt_d = cnt_q - CntOne;
        end else if (!send && credit_i) begin
            if (cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    // State registers: credit counter, sticky overflow flag and the link output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= CntMax;
            ovf_q       <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            dst_valid_q <= send;
            if (send) begin
                dst_data_q <= src_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    // A stalled source must keep its beat stable until it is taken.
    a_src_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        src_valid_i && !src_ready_o |=> $stable(src_valid_i) && $stable(src_data_i));

    if (AssertNoOverflow) begin : g_ovf_check
        // The receiver must never return more credits than it was given.
        a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !$rose(credit_overflow_o));
    end
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// tb/tb_stream_credit_tx.sv - directed self-checking bench for stream_credit_tx
module tb_stream_credit_tx;

    localparam int NC = 4;
    localparam int CW = $clog2(NC + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [7:0]    src_data = '0;
    logic          dst_valid;
    logic [7:0]    dst_data;
    logic          credit = 1'b0;
    logic [CW-1:0] credit_count;
    logic          idle;
    logic          credit_overflow;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference model: available credits as a plain integer, last link beat, sticky overflow.
    int         m_cred = NC;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = '0;
    bit         m_ovf = 1'b0;

    stream_credit_tx #(
        .T                (logic [7:0]),
        .NumCredits       (NC),
        .AssertNoOverflow (1'b0)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .src_valid_i       (src_valid),
        .src_ready_o       (src_ready),
        .src_data_i        (src_data),
        .dst_valid_o       (dst_valid),
        .dst_data_o        (dst_data),
        .credit_i          (credit),
        .credit_count_o    (credit_count),
        .idle_o            (idle),
        .credit_overflow_o (credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model update on every rising edge from the inputs presented before it.
    always @(posedge clk) begin
        int  nxt;
        bit  acc;
        if (rst) begin
            m_cred  = NC;
            m_valid = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
        end else begin
            acc     = src_valid && (m_cred > 0);
            m_valid = acc;
            if (acc) m_data = src_data;
            nxt = m_cred - int'(acc) + int'(credit);
            if (nxt > NC) begin
                m_ovf = 1'b1;
                nxt   = NC;
            end
            m_cred = nxt;
        end
        chk_en = 1'b1;
    end

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_valid", 32'(dst_valid), 32'(m_valid));
            if (m_valid) chk("cyc_data", 32'(dst_data), 32'(m_data));
            chk("cyc_count", 32'(credit_count), 32'(m_cred));
            chk("cyc_ready", 32'(src_ready), 32'(m_cred > 0));
            chk("cyc_idle", 32'(idle), 32'((m_cred == NC) && !m_valid));
            chk("cyc_ovf", 32'(credit_overflow), 32'(m_ovf));
        end
    end

    initial begin
        // Reset, then idle
        step();
        step();
        chk("rst_count", 32'(credit_count), 32'd4);
        chk("rst_ready", 32'(src_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_valid", 32'(dst_valid), 32'd0);
        chk("rst_data", 32'(dst_data), 32'd0);
        chk("rst_ovf", 32'(credit_overflow), 32'd0);
        rst = 1'b0;

        // Credit exhaustion: beats 1..4 go out, 5 stalls
        for (int i = 1; i <= 4; i++) begin
            src_valid = 1'b1;
            src_data  = 8'(i);
            step();
            chk("exh_valid", 32'(dst_valid), 32'd1);
            chk("exh_data", 32'(dst_data), 32'(i));
        end
        src_data = 8'h05;
        chk("exh_ready", 32'(src_ready), 32'd0);
        chk("exh_count", 32'(credit_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(dst_valid), 32'd0);
        end

        // Credit return unblocks beat 5
        credit = 1'b1;
        step();
        credit = 1'b0;
        chk("cred_ready", 32'(src_ready), 32'd1);
        step();
        chk("cred_valid5", 32'(dst_valid), 32'd1);
        chk("cred_data5", 32'(dst_data), 32'h05);
        chk("cred_ready0", 32'(src_ready), 32'd0);
        src_data = 8'h06;
        credit = 1'b1;
        step();
        credit = 1'b0;
        step();
        src_valid = 1'b0;
        chk("cred_data6", 32'(dst_data), 32'h06);
        chk("cred_count0", 32'(credit_count), 32'd0);

        // Bring the count to 2, then send and return a credit each cycle
        credit = 1'b1;
        step();
        step();
        credit = 1'b0;
        chk("two_count", 32'(credit_count), 32'd2);
        src_valid = 1'b1;
        credit    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            src_data = 8'(8'h10 + i);
            step();
            chk("sim_count", 32'(credit_count), 32'd2);
            chk("sim_valid", 32'(dst_valid), 32'd1);
            chk("sim_data", 32'(dst_data), 32'(8'h10 + i));
        end
        src_valid = 1'b0;
        credit    = 1'b0;
        step();

        // Return the remaining two credits
        credit = 1'b1;
        step();
        step();
        credit = 1'b0;
        chk("full_count", 32'(credit_count), 32'd4);
        chk("full_idle", 32'(idle), 32'd1);

        // Overflow: an extra credit saturates and sets the sticky flag
        credit = 1'b1;
        step();
        credit = 1'b0;
        chk("ovf_count", 32'(credit_count), 32'd4);
        chk("ovf_flag", 32'(credit_overflow), 32'd1);
        step();
        step();
        chk("ovf_sticky", 32'(credit_overflow), 32'd1);
        src_valid = 1'b1;
        src_data  = 8'hA5;
        step();
        src_valid = 1'b0;
        chk("ovf_send_valid", 32'(dst_valid), 32'd1);
        chk("ovf_send_data", 32'(dst_data), 32'hA5);
        chk("ovf_send_count", 32'(credit_count), 32'd3);

        // Reset mid-stream with one credit left and a beat in flight
        src_valid = 1'b1;
        src_data  = 8'hB1;
        step();
        src_data = 8'hB2;
        step();
        src_valid = 1'b0;
        chk("mid_count", 32'(credit_count), 32'd1);
        chk("mid_valid", 32'(dst_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_valid", 32'(dst_valid), 32'd0);
        chk("mrst_count", 32'(credit_count), 32'd4);
        chk("mrst_ovf", 32'(credit_overflow), 32'd0);
        chk("mrst_idle", 32'(idle), 32'd1);

        // A credit in the cycle of reset release is taken into account
        rst    = 1'b0;
        credit = 1'b1;
        step();
        credit = 1'b0;
        chk("rel_count", 32'(credit_count), 32'd4);
        chk("rel_ovf", 32'(credit_overflow), 32'd1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
